seq_div: RTL

- Iterative signed integer divider: the inverse operation to the team's Booth multiplier (`mul`).
- Produces one quotient bit per clock using non-restoring division on operand magnitudes, then applies a sign fix-up.
- Sits beside `mul` in the arithmetic datapath.
- Uses a start/done handshake so a controller can launch an operation and collect the result.

---
 rtl/seq_div.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Iterative signed divider: one quotient bit per clock (non-restoring on magnitudes),
// then a sign fix-up. Results truncate toward zero; the remainder follows the dividend's sign.
module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_1,
  input  logic [WIDTH-1:0] op_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int unsigned PW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH:0]   dmag;
  logic [WIDTH-1:0] a_lat;
  logic             a_neg;
  logic             q_neg;
  logic             dz_pend;
  logic             ov_pend;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  logic             accept;
  logic [PW-1:0]    dmag_ext;
  logic [PW-1:0]    pr_sh;
  logic [PW-1:0]    pr_step;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;

  // The done cycle still has busy=1 while the FSM is already in IDLE, so
  // acceptance must look at busy as well as the state.
  assign accept   = (state == S_IDLE) && start && !busy;
  assign dmag_ext = {1'b0, dmag};

  always_comb begin
    a_mag_in = op_1[WIDTH-1] ? -op_1 : op_1;
    b_mag_in = op_2[WIDTH-1] ? -op_2 : op_2;
    pr_sh    = {pr[PW-2:0], dq[WIDTH-1]};
    pr_step  = pr[PW-1] ? (pr_sh + dmag_ext) : (pr_sh - dmag_ext);
    rem_mag  = pr[PW-1] ? WIDTH'(pr + dmag_ext) : pr[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_CALC;
      S_CALC: if (cnt == CW'(1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pr          <= '0;
      dq          <= '0;
      dmag        <= '0;
      a_lat       <= '0;
      a_neg       <= 1'b0;
      q_neg       <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      q_res       <= '0;
      r_res       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_lat       <= op_1;
            a_neg       <= op_1[WIDTH-1];
            q_neg       <= op_1[WIDTH-1] ^ op_2[WIDTH-1];
            dq          <= a_mag_in;
            dmag        <= {1'b0, b_mag_in};
            dz_pend     <= (op_2 == '0);
            ov_pend     <= (op_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op_2 == '1);
            pr          <= '0;
            cnt         <= CW'(WIDTH);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
          end
        end
        S_CALC: begin
          pr  <= pr_step;
          dq  <= {dq[WIDTH-2:0], ~pr_step[PW-1]};
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (dz_pend) begin
            q_res <= '1;
            r_res <= a_lat;
          end else if (ov_pend) begin
            q_res <= {1'b1, {(WIDTH-1){1'b0}}};
            r_res <= '0;
          end else begin
            q_res <= q_neg ? -dq : dq;
            r_res <= a_neg ? -rem_mag : rem_mag;
          end
        end
        S_DONE: begin
          quotient    <= q_res;
          remainder   <= r_res;
          div_by_zero <= dz_pend;
          ovf         <= ov_pend;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
